// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: shared forwarding-select encodings and shadow-slot layout for hazard_unit.
package riscv_hazard_pkg;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memtoreg;
  } slot_t;
  localparam slot_t SLOT_NONE = '0;
  function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] rs, logic use_rs);
    return s.valid && s.regwrite && (s.rd != REG_X0) && use_rs && (s.rd == rs);
  endfunction
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: matches one ID source operand against the ex and mem shadow slots.
module hazard_cmp
  import riscv_hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  slot_t            ex,
  input  slot_t            mem,
  output logic             hit_ex,
  output logic             hit_mem,
  output logic             load_hit
);
  always_comb begin
    hit_ex   = slot_hit(ex, rs, use_rs);
    hit_mem  = slot_hit(mem, rs, use_rs);
    load_hit = hit_ex && ex.memtoreg;
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall/bubble control and registered EX forwarding selects.
// Optional stall_count statistics counter is enabled by defining HU_STATS_EN.
module hazard_unit
  import riscv_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memtoreg,
  input  logic       flush,
  output logic       stall,
  output logic       idex_bubble,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
`ifdef HU_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);
  slot_t ex_q, mem_q, wb_q;
  fwd_sel_t sel_a, sel_b, fwd_a_q, fwd_b_q;
  logic hit_ex_a, hit_mem_a, load_a, hit_ex_b, hit_mem_b, load_b;

  hazard_cmp cmp_a (
    .rs(id_rs1), .use_rs(id_use_rs1), .ex(ex_q), .mem(mem_q),
    .hit_ex(hit_ex_a), .hit_mem(hit_mem_a), .load_hit(load_a)
  );

  hazard_cmp cmp_b (
    .rs(id_rs2), .use_rs(id_use_rs2), .ex(ex_q), .mem(mem_q),
    .hit_ex(hit_ex_b), .hit_mem(hit_mem_b), .load_hit(load_b)
  );

  // ex holds the younger producer, so it is checked before mem
  always_comb begin
    stall       = id_valid && !flush && (load_a || load_b);
    idex_bubble = stall || flush;
    sel_a       = (hit_ex_a && !ex_q.memtoreg) ? FWD_MEM : hit_mem_a ? FWD_WB : FWD_REG;
    sel_b       = (hit_ex_b && !ex_q.memtoreg) ? FWD_MEM : hit_mem_b ? FWD_WB : FWD_REG;
    fwd_a_sel   = fwd_a_q;
    fwd_b_sel   = fwd_b_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_q    <= SLOT_NONE;
      mem_q   <= SLOT_NONE;
      wb_q    <= SLOT_NONE;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= idex_bubble ? SLOT_NONE : slot_t'{id_valid, id_rd, id_regwrite, id_memtoreg};
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= idex_bubble ? FWD_REG : sel_a;
      fwd_b_q <= idex_bubble ? FWD_REG : sel_b;
    end

`ifdef HU_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_count <= '0;
    else if (stall && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed instruction sequences plus random traffic against an in-flight pipeline model.
module tb_hazard_unit;
  logic       clk = 1'b0, reset = 1'b1;
  logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_regwrite = 1'b0, id_memtoreg = 1'b0, flush = 1'b0;
  logic       stall, idex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HU_STATS_EN
  logic [31:0] stall_count;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .flush(flush),
    .stall(stall), .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HU_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic rw, ld, fl;
    logic st, bu; logic [1:0] fa, fb;
  } vec_t;

  // in-flight instructions downstream of ID: index 0 = EX, 1 = MEM, 2 = WB
  typedef struct { bit v; bit [4:0] rd; bit rw; bit ld; } ent_t;
  ent_t pipe[3];
  bit [1:0] m_fa, m_fb;
  longint m_cnt;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic fl, input logic st,
                              input logic bu, input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r = '{v, rs1, rs2, u1, u2, rd, rw, ld, fl, st, bu, fa, fb};
    return r;
  endfunction

  function automatic bit writes(input int i, input bit [4:0] r);
    return pipe[i].v && pipe[i].rw && pipe[i].rd == r && r != 0;
  endfunction

  function automatic bit [1:0] fwd_for(input bit [4:0] r, input bit u);
    if (!u) return 2'b00;
    if (writes(0, r) && !pipe[0].ld) return 2'b01;
    if (writes(1, r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit load_use(input bit [4:0] r, input bit u);
    return u && writes(0, r) && pipe[0].ld;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.v; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    id_rd = v.rd; id_regwrite = v.rw; id_memtoreg = v.ld; flush = v.fl;
  endtask

  // entered 1 time unit after a rising edge; leaves 1 time unit after the next one
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    bit e_st, bub;
    drive(v);
    #4;
    e_st = v.v && !v.fl && (load_use(v.rs1, v.u1) || load_use(v.rs2, v.u2));
    bub  = e_st || v.fl;
    chk({tag, " stall"}, {31'd0, stall}, {31'd0, e_st});
    chk({tag, " bubble"}, {31'd0, idex_bubble}, {31'd0, bub});
    chk({tag, " fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, m_fa});
    chk({tag, " fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, m_fb});
`ifdef HU_STATS_EN
    chk({tag, " stall_count"}, stall_count, m_cnt[31:0]);
`endif
    if (use_tbl) begin
      chk({tag, " tbl_stall"}, {31'd0, stall}, {31'd0, v.st});
      chk({tag, " tbl_bubble"}, {31'd0, idex_bubble}, {31'd0, v.bu});
      chk({tag, " tbl_fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, v.fa});
      chk({tag, " tbl_fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, v.fb});
    end
    @(posedge clk);
    m_fa = bub ? 2'b00 : fwd_for(v.rs1, v.u1);
    m_fb = bub ? 2'b00 : fwd_for(v.rs2, v.u2);
    if (e_st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = bub ? '{0, 0, 0, 0} : '{v.v, v.rd, v.rw, v.ld};
    #1;
  endtask

  vec_t tbl[21];
  vec_t nop, r;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    //              v rs1 rs2 u1 u2 rd rw ld fl  st bu fa     fb
    tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00); // sub x6,x5,x1
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00); // sub in EX
    tbl[3]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[4]  = nop;
    tbl[5]  = mk(1, 1, 5, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00); // or x7,x1,x5
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10); // or in EX
    tbl[7]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00); // lw x5
    tbl[8]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 1, 2'b00, 2'b00); // add x6,x5,x5 stalls
    tbl[9]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00); // held add
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10); // add in EX
    tbl[11] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00); // lw x5
    tbl[12] = mk(1, 5, 0, 1, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00); // add + flush
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00); // addi x0
    tbl[15] = mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00); // add x6,x0,x0
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[17] = mk(1, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00); // addi x5
    tbl[18] = mk(1, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00); // addi x5
    tbl[19] = mk(1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00); // add x6,x5,x0
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00); // youngest wins

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset bubble", {31'd0, idex_bubble}, 32'd0);
    chk("reset fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("reset fwd_b", {30'd0, fwd_b_sel}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
`ifdef HU_STATS_EN
    chk("stall_count after table", stall_count, 32'd1);
`endif

    // reset during a stall, with a live forward select visible
    step(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_add");
    step(mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0), 1'b0, "pre_rst_lw");
    drive(mk(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
    #4;
    chk("mid stall", {31'd0, stall}, 32'd1);
    chk("mid fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async rst stall", {31'd0, stall}, 32'd0);
    chk("async rst bubble", {31'd0, idex_bubble}, 32'd0);
    chk("async rst fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("async rst fwd_b", {30'd0, fwd_b_sel}, 32'd0);
`ifdef HU_STATS_EN
    chk("async rst count", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(mk(1, 6, 7, 1, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00), 1'b1, "post_rst");
    step(nop, 1'b1, "post_rst_ex");

    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
             0, 0, 0, 0);
      step(r, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
